dual_peak_window: RTL and testbench



---
 rtl/dual_peak_window.sv | 106 ++++++++++
 tb/tb_dual_peak_window.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_peak_window.sv
// Per-channel peak tracker over WIN_LEN interleaved 730/850 sample pairs, published to the MCU with valid/ack.
// Latency: maxima and out_vld update on the edge that accepts the window's last 850 sample.
// Backpressure: none toward the collector; a publish over an unacked pair overwrites it and sets sticky overrun.
module dual_peak_window #(
    parameter int WIN_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ampl,
    input  logic          ampl_vld,
    input  logic          chan_sync,
    output logic [AW-1:0] max730,
    output logic [AW-1:0] max850,
    output logic          out_vld,
    input  logic          out_ack,
    output logic          overrun,
    output logic          win_busy
);

    localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

    typedef enum logic {
        PH730 = 1'b0,
        PH850 = 1'b1
    } phase_t;

    phase_t        phase, phase_nxt;
    logic [CW-1:0] pair_cnt, pair_cnt_nxt;
    logic [AW-1:0] run730, run730_nxt;
    logic [AW-1:0] run850, run850_nxt;
    logic [AW-1:0] max730_nxt, max850_nxt;
    logic          out_vld_nxt, overrun_nxt, win_busy_nxt;
    logic          accept, first, publish;
    logic [AW-1:0] s730, s850;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH730;
            pair_cnt <= '0;
            run730   <= '0;
            run850   <= '0;
            max730   <= '0;
            max850   <= '0;
            out_vld  <= 1'b0;
            overrun  <= 1'b0;
            win_busy <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            pair_cnt <= pair_cnt_nxt;
            run730   <= run730_nxt;
            run850   <= run850_nxt;
            max730   <= max730_nxt;
            max850   <= max850_nxt;
            out_vld  <= out_vld_nxt;
            overrun  <= overrun_nxt;
            win_busy <= win_busy_nxt;
        end
    end

    always_comb begin
        phase_nxt    = phase;
        pair_cnt_nxt = pair_cnt;
        run730_nxt   = run730;
        run850_nxt   = run850;
        max730_nxt   = max730;
        max850_nxt   = max850;
        win_busy_nxt = win_busy;

        accept  = ampl_vld & ~chan_sync;
        first   = (pair_cnt == '0);
        // The first pair of a window reloads rather than compares, so stale maxima never leak across windows.
        s730    = (first || (ampl > run730)) ? ampl : run730;
        s850    = (first || (ampl > run850)) ? ampl : run850;
        publish = accept && (phase == PH850) && (pair_cnt == LAST);

        if (chan_sync) begin
            phase_nxt    = PH730;
            pair_cnt_nxt = '0;
            win_busy_nxt = 1'b0;
        end else if (ampl_vld) begin
            if (phase == PH730) begin
                run730_nxt   = s730;
                phase_nxt    = PH850;
                win_busy_nxt = 1'b1;
            end else begin
                run850_nxt = s850;
                phase_nxt  = PH730;
                if (pair_cnt == LAST) begin
                    max730_nxt   = run730;
                    max850_nxt   = s850;
                    pair_cnt_nxt = '0;
                    win_busy_nxt = 1'b0;
                end else begin
                    pair_cnt_nxt = pair_cnt + CW'(1);
                end
            end
        end

        // A publish outranks a same-cycle ack: the new pair stays pending.
        out_vld_nxt = publish | (out_vld & ~out_ack);
        overrun_nxt = (publish & out_vld & ~out_ack) | (overrun & ~out_ack);
    end

endmodule

// File: tb/tb_dual_peak_window.sv
// Drives three window lengths (2, 1, 5) from one stimulus stream; a per-cycle scoreboard compares against a window-buffer model.
module tb_dual_peak_window;

    typedef struct packed {
        logic [3:0] m730;
        logic [3:0] m850;
        logic       vld;
        logic       ovr;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ampl = '0;
    logic       ampl_vld = 1'b0;
    logic       chan_sync = 1'b0;
    logic       out_ack = 1'b0;

    logic [3:0] d_m730 [3];
    logic [3:0] d_m850 [3];
    logic       d_vld  [3];
    logic       d_ovr  [3];
    logic       d_busy [3];
    obs_t       act    [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_peak_window #(.WIN_LEN(2), .AW(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ampl(ampl), .ampl_vld(ampl_vld), .chan_sync(chan_sync),
        .max730(d_m730[0]), .max850(d_m850[0]), .out_vld(d_vld[0]), .out_ack(out_ack),
        .overrun(d_ovr[0]), .win_busy(d_busy[0]));

    dual_peak_window #(.WIN_LEN(1), .AW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ampl(ampl), .ampl_vld(ampl_vld), .chan_sync(chan_sync),
        .max730(d_m730[1]), .max850(d_m850[1]), .out_vld(d_vld[1]), .out_ack(out_ack),
        .overrun(d_ovr[1]), .win_busy(d_busy[1]));

    dual_peak_window #(.WIN_LEN(5), .AW(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .ampl(ampl), .ampl_vld(ampl_vld), .chan_sync(chan_sync),
        .max730(d_m730[2]), .max850(d_m850[2]), .out_vld(d_vld[2]), .out_ack(out_ack),
        .overrun(d_ovr[2]), .win_busy(d_busy[2]));

    assign act[0] = {d_m730[0], d_m850[0], d_vld[0], d_ovr[0], d_busy[0]};
    assign act[1] = {d_m730[1], d_m850[1], d_vld[1], d_ovr[1], d_busy[1]};
    assign act[2] = {d_m730[2], d_m850[2], d_vld[2], d_ovr[2], d_busy[2]};

    // Reference model: samples of the open window are buffered; maxima are taken over the buffer at publish.
    int         wl [3] = '{2, 1, 5};
    int         n730 [3];
    int         n850 [3];
    logic [3:0] b730 [3][256];
    logic [3:0] b850 [3][256];
    logic [3:0] mx730 [3];
    logic [3:0] mx850 [3];
    logic       mv [3];
    logic       mo [3];
    obs_t [2:0] sb_q [$];
    int         cyc = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            n730[k] = 0;  n850[k] = 0;
            mx730[k] = '0; mx850[k] = '0;
            mv[k] = 1'b0; mo[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input logic [3:0] a, input logic s, input logic k_ack);
        obs_t [2:0] e;
        logic       pub;
        logic [3:0] p730, p850;
        for (int k = 0; k < 3; k++) begin
            pub = 1'b0;
            p730 = '0;
            p850 = '0;
            if (s) begin
                n730[k] = 0;
                n850[k] = 0;
            end else if (v) begin
                if (n730[k] == n850[k]) begin
                    b730[k][n730[k]] = a;
                    n730[k]++;
                end else begin
                    b850[k][n850[k]] = a;
                    n850[k]++;
                    if (n850[k] == wl[k]) begin
                        pub = 1'b1;
                        for (int i = 0; i < wl[k]; i++) begin
                            if (b730[k][i] > p730) p730 = b730[k][i];
                            if (b850[k][i] > p850) p850 = b850[k][i];
                        end
                        n730[k] = 0;
                        n850[k] = 0;
                    end
                end
            end
            if (pub) begin
                if (mv[k] && !k_ack) mo[k] = 1'b1;
                else if (k_ack)      mo[k] = 1'b0;
                mv[k] = 1'b1;
                mx730[k] = p730;
                mx850[k] = p850;
            end else if (k_ack) begin
                mv[k] = 1'b0;
                mo[k] = 1'b0;
            end
            e[k] = '{m730: mx730[k], m850: mx850[k], vld: mv[k], ovr: mo[k], busy: (n730[k] > 0)};
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic s, input logic k_ack);
        ampl_vld = v; ampl = a; chan_sync = s; out_ack = k_ack;
        model_step(v, a, s, k_ack);
        @(posedge clk);
        #1;
        ampl_vld = 1'b0; chan_sync = 1'b0; out_ack = 1'b0;
    endtask

    task automatic samples(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
        step(1'b1, a0, 1'b0, 1'b0);
        step(1'b1, a1, 1'b0, 1'b0);
        step(1'b1, a2, 1'b0, 1'b0);
        step(1'b1, a3, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_inst%0d", nm, k), 32'(act[k]), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        obs_t [2:0] e;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== e[k]) begin
                    errors++;
                    $display("FAIL sb inst%0d cyc%0d: got m730=%0d m850=%0d vld=%b ovr=%b busy=%b want m730=%0d m850=%0d vld=%b ovr=%b busy=%b",
                             k, cyc, act[k].m730, act[k].m850, act[k].vld, act[k].ovr, act[k].busy,
                             e[k].m730, e[k].m850, e[k].vld, e[k].ovr, e[k].busy);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk_zero("reset");
        #10;
        rst_n = 1'b1;

        // Two windows on WIN_LEN=2; second is published over an unacked pair.
        samples(4'd3, 4'd5, 4'd9, 4'd2);
        chk("w1_m730", 32'(d_m730[0]), 32'd9);
        chk("w1_m850", 32'(d_m850[0]), 32'd5);
        chk("w1_vld",  32'(d_vld[0]),  32'd1);
        chk("w1_ovr",  32'(d_ovr[0]),  32'd0);
        samples(4'd1, 4'd15, 4'd4, 4'd0);
        chk("w2_m730", 32'(d_m730[0]), 32'd4);
        chk("w2_m850", 32'(d_m850[0]), 32'd15);
        chk("w2_ovr",  32'(d_ovr[0]),  32'd1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("ack_vld", 32'(d_vld[0]), 32'd0);
        chk("ack_ovr", 32'(d_ovr[0]), 32'd0);

        // chan_sync mid-window with a coincident strobe that must be dropped.
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd14, 1'b1, 1'b0);
        chk("sync_busy", 32'(d_busy[0]), 32'd0);
        samples(4'd2, 4'd3, 4'd1, 4'd6);
        chk("sync_m730", 32'(d_m730[0]), 32'd2);
        chk("sync_m850", 32'(d_m850[0]), 32'd6);

        // Ack coincident with a publish: pending stays high, no overrun.
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd6, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b1);
        chk("coin_vld",  32'(d_vld[0]),  32'd1);
        chk("coin_ovr",  32'(d_ovr[0]),  32'd0);
        chk("coin_m730", 32'(d_m730[0]), 32'd7);
        chk("coin_m850", 32'(d_m850[0]), 32'd8);

        // WIN_LEN=1 extremes: all-zero pair then all-ones pair.
        step(1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b0);
        chk("wl1_zero_m730", 32'(d_m730[1]), 32'd0);
        chk("wl1_zero_m850", 32'(d_m850[1]), 32'd0);
        chk("wl1_zero_vld",  32'(d_vld[1]),  32'd1);
        step(1'b1, 4'd15, 1'b0, 1'b0);
        step(1'b1, 4'd15, 1'b0, 1'b0);
        chk("wl1_full_m730", 32'(d_m730[1]), 32'd15);
        chk("wl1_full_m850", 32'(d_m850[1]), 32'd15);
        chk("wl1_full_ovr",  32'(d_ovr[1]),  32'd1);

        // Asynchronous reset three samples into a window.
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        #20;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        samples(4'd8, 4'd1, 4'd2, 4'd3);
        chk("post_rst_m730", 32'(d_m730[0]), 32'd8);
        chk("post_rst_m850", 32'(d_m850[0]), 32'd3);

        // Randomised traffic, checked by the scoreboard alone.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
